// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_pkg;

  localparam int DEFAULT_DATA_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT_W,
    ST_EMIT_W,
    ST_LATCH,
    ST_STREAM,
    ST_FLUSH,
    ST_SETTLE,
    ST_OUTPUT
  } seq_state_e;

  // Bit offset of a lane inside a packed vector of lanes.
  function automatic int lane_lsb(input int lane, input int bits);
    return lane * bits;
  endfunction

endpackage

// File: rtl/systolic_skew_buffer.sv
// Triangular delay line: lane r of the output is lane r of the input delayed by r cycles.
module systolic_skew_buffer
  import systolic_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int ARRAY_SIZE = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic [ARRAY_SIZE*DATA_BITS-1:0] in_vec,
  output logic [ARRAY_SIZE*DATA_BITS-1:0] out_vec
);

  for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_lane
    if (r == 0) begin : g_direct
      assign out_vec[lane_lsb(0, DATA_BITS) +: DATA_BITS] = in_vec[lane_lsb(0, DATA_BITS) +: DATA_BITS];
    end else begin : g_delay
      logic [DATA_BITS-1:0] pipe [r];

      // Shift this lane's value one stage per cycle; clear empties the lane for a new job.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < r; i++) pipe[i] <= '0;
        end else if (clear) begin
          for (int i = 0; i < r; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= in_vec[lane_lsb(r, DATA_BITS) +: DATA_BITS];
          for (int i = 1; i < r; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign out_vec[lane_lsb(r, DATA_BITS) +: DATA_BITS] = pipe[r-1];
    end
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequencer for the NxN weight-stationary systolic array: weight load, skewed
// activation streaming, flush, and row-by-row result readout.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | waiting for the first weight row
//  COLLECT_W  | buffering the remaining weight rows
//  EMIT_W     | driving buffered rows onto the north edge, N cycles
//  LATCH      | one-cycle load_weights pulse
//  STREAM     | accepting activations (bubbles when none offered)
//  FLUSH      | injecting zeros for 2*(N-1) cycles to drain the wavefront
//  SETTLE     | compute held off one cycle so accumulators are stable
//  OUTPUT     | handing result rows out, one per r_valid/r_ready transfer
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int ARRAY_SIZE = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       w_valid,
  output logic                                       w_ready,
  input  logic [ARRAY_SIZE*DATA_BITS-1:0]            w_data,
  input  logic                                       a_valid,
  output logic                                       a_ready,
  input  logic [ARRAY_SIZE*DATA_BITS-1:0]            a_data,
  input  logic                                       a_last,
  output logic [ARRAY_SIZE*DATA_BITS-1:0]            b_out,
  output logic [ARRAY_SIZE*DATA_BITS-1:0]            a_out,
  output logic                                       clear_acc,
  output logic                                       load_weights,
  output logic                                       compute_enable,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_BITS-1:0] results_in,
  output logic                                       r_valid,
  input  logic                                       r_ready,
  output logic [ARRAY_SIZE*DATA_BITS-1:0]            r_data,
  output logic                                       r_last,
  output logic                                       busy
);

  localparam int N         = ARRAY_SIZE;
  localparam int VW        = N * DATA_BITS;
  localparam int IW        = (N > 1) ? $clog2(N) : 1;
  localparam int FLUSH_CYC = 2 * (N - 1);
  localparam int FW        = $clog2(FLUSH_CYC + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  seq_state_e     state, state_nxt;
  logic [VW-1:0]  wbuf [N];
  logic [IW-1:0]  widx, kidx, ridx;
  logic [FW-1:0]  fcnt;
  logic [VW-1:0]  inj_vec;
  logic           skew_clear;
  logic           w_fire, a_fire, r_fire;

  assign w_fire = w_valid & w_ready;
  assign a_fire = a_valid & a_ready;
  assign r_fire = r_valid & r_ready;
  assign busy   = (state != ST_IDLE);

  // State register, weight buffer, and the emit/flush/readout counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      widx  <= '0;
      kidx  <= '0;
      ridx  <= '0;
      fcnt  <= '0;
      for (int i = 0; i < N; i++) wbuf[i] <= '0;
    end else begin
      state <= state_nxt;
      if (w_fire) begin
        wbuf[widx] <= w_data;
        widx       <= (widx == LAST_IDX) ? '0 : widx + 1'b1;
      end
      if (state == ST_EMIT_W) kidx <= (kidx == LAST_IDX) ? '0 : kidx + 1'b1;
      // Flush timer is a down-counter loaded on the final activation.
      if (state == ST_STREAM && a_fire && a_last) fcnt <= FW'(FLUSH_CYC);
      else if (state == ST_FLUSH)                 fcnt <= fcnt - 1'b1;
      if (r_fire) ridx <= (ridx == LAST_IDX) ? '0 : ridx + 1'b1;
    end
  end

  // Next-state and array/stream control decode.
  always_comb begin
    state_nxt      = state;
    w_ready        = 1'b0;
    a_ready        = 1'b0;
    b_out          = '0;
    clear_acc      = 1'b0;
    load_weights   = 1'b0;
    compute_enable = 1'b0;
    r_valid        = 1'b0;
    r_data         = '0;
    r_last         = 1'b0;
    inj_vec        = '0;
    skew_clear     = 1'b0;
    case (state)
      ST_IDLE, ST_COLLECT_W: begin
        w_ready = 1'b1;
        if (w_valid) state_nxt = (widx == LAST_IDX) ? ST_EMIT_W : ST_COLLECT_W;
      end
      ST_EMIT_W: begin
        b_out     = wbuf[kidx];
        clear_acc = (kidx == '0);
        if (kidx == LAST_IDX) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        load_weights = 1'b1;
        skew_clear   = 1'b1;
        state_nxt    = ST_STREAM;
      end
      ST_STREAM: begin
        a_ready        = 1'b1;
        compute_enable = 1'b1;
        if (a_valid) begin
          inj_vec = a_data;
          if (a_last) state_nxt = (FLUSH_CYC == 0) ? ST_SETTLE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        compute_enable = 1'b1;
        if (fcnt == FW'(1)) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: state_nxt = ST_OUTPUT;
      ST_OUTPUT: begin
        r_valid = 1'b1;
        r_data  = results_in[lane_lsb(int'(ridx) * N, DATA_BITS) +: VW];
        r_last  = (ridx == LAST_IDX);
        if (r_ready && ridx == LAST_IDX) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  systolic_skew_buffer #(
    .DATA_BITS  (DATA_BITS),
    .ARRAY_SIZE (ARRAY_SIZE)
  ) u_skew (
    .clk     (clk),
    .reset   (reset),
    .clear   (skew_clear),
    .in_vec  (inj_vec),
    .out_vec (a_out)
  );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with N=4, 16-bit lanes.
module tb_systolic_sequencer;

  localparam int DB = 16;
  localparam int N  = 4;
  localparam int VW = N * DB;

  logic            clk = 1'b0;
  logic            reset;
  logic            w_valid, w_ready;
  logic [VW-1:0]   w_data;
  logic            a_valid, a_ready;
  logic [VW-1:0]   a_data;
  logic            a_last;
  logic [VW-1:0]   b_out, a_out;
  logic            clear_acc, load_weights, compute_enable;
  logic [N*VW-1:0] results_in;
  logic            r_valid, r_ready;
  logic [VW-1:0]   r_data;
  logic            r_last, busy;

  int total = 0;
  int bad   = 0;

  logic [VW-1:0] emit_seen [N];
  logic          latch_ld;
  logic [VW-1:0] latch_b;

  systolic_sequencer #(.DATA_BITS(DB), .ARRAY_SIZE(N)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .b_out(b_out), .a_out(a_out),
    .clear_acc(clear_acc), .load_weights(load_weights), .compute_enable(compute_enable),
    .results_in(results_in),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mkvec(input logic [15:0] base);
    logic [VW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DB +: DB] = base + 16'(c);
    return v;
  endfunction

  function automatic logic [VW-1:0] wbeat(input int i);
    logic [VW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DB +: DB] = 16'(i + 1) | 16'(c << 8);
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_row(input int r);
    logic [VW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DB +: DB] = 16'hA000 + 16'(r * 16 + c);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loads four back-to-back weight rows and stops sampling in the LATCH cycle.
  task automatic run_weights(input logic [15:0] base);
    for (int i = 0; i < N; i++) begin
      w_valid = 1'b1;
      w_data  = mkvec(base + 16'(i * 16));
      step();
    end
    w_valid = 1'b0;
    w_data  = '0;
    for (int k = 0; k < N; k++) begin
      #1;
      emit_seen[k] = b_out;
      step();
    end
    #1;
    latch_ld = load_weights;
    latch_b  = b_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL reset_w_ready got=%b want=1", w_ready); end
    total++;
    if ({a_ready, b_out, a_out, clear_acc, load_weights, compute_enable, r_valid, r_data, r_last, busy} !== '0) begin
      bad++; $display("FAIL reset_outputs got b=%h a=%h ce=%b rv=%b busy=%b want all 0", b_out, a_out, compute_enable, r_valid, busy);
    end
    reset = 1'b0;
    step();
    #1;
    total++; if (busy !== 1'b0 || w_ready !== 1'b1) begin bad++; $display("FAIL reset_release busy=%b w_ready=%b want 0/1", busy, w_ready); end
  endtask

  task automatic test_weight_load();
    for (int i = 0; i < N; i++) begin
      w_valid = 1'b1;
      w_data  = wbeat(i);
      #1;
      total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL wload_ready beat=%0d got=%b want=1", i, w_ready); end
      step();
      w_valid = 1'b0;
      w_data  = '0;
      if (i < N - 1) begin
        #1;
        total++; if (b_out !== '0) begin bad++; $display("FAIL wload_gap_b beat=%0d got=%h want=0", i, b_out); end
        step();
      end
    end
    for (int k = 0; k < N; k++) begin
      #1;
      total++; if (b_out !== wbeat(k)) begin bad++; $display("FAIL emit_b k=%0d got=%h want=%h", k, b_out, wbeat(k)); end
      total++; if (clear_acc !== (k == 0)) begin bad++; $display("FAIL emit_clear k=%0d got=%b want=%b", k, clear_acc, (k == 0)); end
      total++; if (load_weights !== 1'b0 || compute_enable !== 1'b0) begin bad++; $display("FAIL emit_ctrl k=%0d ld=%b ce=%b want 0/0", k, load_weights, compute_enable); end
      step();
    end
    #1;
    total++; if (load_weights !== 1'b1) begin bad++; $display("FAIL latch_ld got=%b want=1", load_weights); end
    total++; if (b_out !== '0 || compute_enable !== 1'b0 || clear_acc !== 1'b0) begin bad++; $display("FAIL latch_ctrl b=%h ce=%b clr=%b want 0", b_out, compute_enable, clear_acc); end
  endtask

  // Entered while sampling the LATCH cycle left by test_weight_load.
  task automatic test_single_activation();
    logic [VW-1:0] act, expv;
    int ce_cnt, first_rv;
    act = {16'h0800, 16'h1000, 16'h2000, 16'h4000};
    a_valid = 1'b1; a_data = act; a_last = 1'b1;
    #1;
    total++; if (a_ready !== 1'b0 || a_out !== '0) begin bad++; $display("FAIL act_latch a_ready=%b a_out=%h want 0", a_ready, a_out); end
    step();
    ce_cnt = 0; first_rv = -1;
    for (int j = 0; j < 10; j++) begin
      if (j == 1) begin a_valid = 1'b0; a_data = '0; a_last = 1'b0; end
      #1;
      for (int r = 0; r < N; r++) expv[r*DB +: DB] = (j == r) ? act[r*DB +: DB] : 16'h0000;
      total++; if (a_out !== expv) begin bad++; $display("FAIL skew_single j=%0d got=%h want=%h", j, a_out, expv); end
      if (compute_enable) ce_cnt++;
      if (r_valid && first_rv < 0) first_rv = j;
      step();
    end
    total++; if (ce_cnt !== 7) begin bad++; $display("FAIL ce_window got=%0d want=7", ce_cnt); end
    total++; if (first_rv !== 8) begin bad++; $display("FAIL single_rv_latency got=%0d want=8", first_rv); end
    r_ready = 1'b1;
    for (int row = 0; row < N; row++) begin
      #1;
      total++; if (r_valid !== 1'b1 || r_data !== exp_row(row)) begin bad++; $display("FAIL single_row row=%0d rv=%b got=%h want=%h", row, r_valid, r_data, exp_row(row)); end
      total++; if (r_last !== (row == N - 1)) begin bad++; $display("FAIL single_last row=%0d got=%b", row, r_last); end
      step();
    end
    r_ready = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle busy=%b want=0", busy); end
  endtask

  task automatic test_bubbles();
    logic [VW-1:0] inj [16];
    logic [VW-1:0] expv;
    run_weights(16'h0300);
    total++; if (latch_ld !== 1'b1) begin bad++; $display("FAIL bub_latch got=%b want=1", latch_ld); end
    for (int i = 0; i < 16; i++) inj[i] = '0;
    inj[0] = mkvec(16'h1100);
    inj[3] = mkvec(16'h2200);
    inj[4] = mkvec(16'h3300);
    step();
    for (int j = 0; j < 14; j++) begin
      a_valid = (j == 0 || j == 3 || j == 4);
      a_data  = inj[j];
      a_last  = (j == 4);
      #1;
      for (int r = 0; r < N; r++) expv[r*DB +: DB] = (j >= r) ? inj[j-r][r*DB +: DB] : 16'h0000;
      total++; if (a_out !== expv) begin bad++; $display("FAIL skew_bubble j=%0d got=%h want=%h", j, a_out, expv); end
      total++; if (compute_enable !== (j <= 10)) begin bad++; $display("FAIL bub_ce j=%0d got=%b want=%b", j, compute_enable, (j <= 10)); end
      total++; if (r_valid !== (j >= 12)) begin bad++; $display("FAIL bub_rv j=%0d got=%b want=%b", j, r_valid, (j >= 12)); end
      step();
    end
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
  endtask

  // Entered in OUTPUT with row 0 pending.
  task automatic test_result_backpressure();
    int ridx_exp, hold;
    ridx_exp = 0; hold = 0;
    for (int n = 0; n < 20 && ridx_exp < N; n++) begin
      r_ready = !(ridx_exp == 2 && hold < 3);
      #1;
      total++; if (r_valid !== 1'b1 || r_data !== exp_row(ridx_exp)) begin bad++; $display("FAIL bp_row n=%0d rv=%b got=%h want=%h", n, r_valid, r_data, exp_row(ridx_exp)); end
      total++; if (r_last !== (ridx_exp == N - 1)) begin bad++; $display("FAIL bp_last n=%0d got=%b", n, r_last); end
      if (r_ready) ridx_exp++; else hold++;
      step();
    end
    r_ready = 1'b0;
    total++; if (ridx_exp !== N || hold !== 3) begin bad++; $display("FAIL bp_count rows=%0d hold=%0d want 4/3", ridx_exp, hold); end
    #1;
    total++; if (busy !== 1'b0 || r_valid !== 1'b0) begin bad++; $display("FAIL bp_idle busy=%b rv=%b want 0/0", busy, r_valid); end
  endtask

  task automatic test_reset_mid_flush();
    int n;
    run_weights(16'h0500);
    a_valid = 1'b1; a_data = mkvec(16'h7000); a_last = 1'b1;
    step();
    step();
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    step();
    step();
    #1;
    total++; if (compute_enable !== 1'b1 || a_ready !== 1'b0) begin bad++; $display("FAIL pre_reset_flush ce=%b a_ready=%b want 1/0", compute_enable, a_ready); end
    reset = 1'b1;
    #1;
    total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL midrst_w_ready got=%b want=1", w_ready); end
    total++;
    if ({a_ready, b_out, a_out, clear_acc, load_weights, compute_enable, r_valid, r_data, r_last, busy} !== '0) begin
      bad++; $display("FAIL midrst_outputs a=%h ce=%b rv=%b busy=%b want all 0", a_out, compute_enable, r_valid, busy);
    end
    step();
    reset = 1'b0;
    #1;
    run_weights(16'h0900);
    for (int k = 0; k < N; k++) begin
      total++; if (emit_seen[k] !== mkvec(16'h0900 + 16'(k * 16))) begin bad++; $display("FAIL postrst_emit k=%0d got=%h want=%h", k, emit_seen[k], mkvec(16'h0900 + 16'(k * 16))); end
    end
    total++; if (latch_ld !== 1'b1 || latch_b !== '0) begin bad++; $display("FAIL postrst_latch ld=%b b=%h want 1/0", latch_ld, latch_b); end
    a_valid = 1'b1; a_data = mkvec(16'h6000); a_last = 1'b1;
    step();
    n = 0;
    while (n < 20) begin
      if (n >= 1) begin a_valid = 1'b0; a_data = '0; a_last = 1'b0; end
      #1;
      if (r_valid) break;
      step();
      n++;
    end
    total++; if (n !== 8) begin bad++; $display("FAIL postrst_rv_latency got=%0d want=8", n); end
    r_ready = 1'b1;
    for (int row = 0; row < N; row++) begin
      total++; if (r_data !== exp_row(row) || r_last !== (row == N - 1)) begin bad++; $display("FAIL postrst_row row=%0d got=%h last=%b", row, r_data, r_last); end
      step();
      #1;
    end
    r_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL postrst_idle busy=%b want=0", busy); end
  endtask

  task automatic test_w_blocked();
    int rows, wr_hi;
    logic done;
    run_weights(16'h0200);
    w_valid = 1'b1; w_data = wbeat(10);
    a_valid = 1'b1; a_data = mkvec(16'h5000); a_last = 1'b1;
    r_ready = 1'b1;
    rows = 0; wr_hi = 0; done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      if (n == 2) begin a_valid = 1'b0; a_data = '0; a_last = 1'b0; end
      if (n > 0) #1;
      if (!busy) done = 1'b1;
      else begin
        if (w_ready) wr_hi++;
        if (r_valid) begin
          total++; if (r_data !== exp_row(rows) || r_last !== (rows == N - 1)) begin bad++; $display("FAIL wblk_row row=%0d got=%h last=%b", rows, r_data, r_last); end
          rows++;
        end
        step();
      end
    end
    r_ready = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL wblk_timeout busy=%b want=0 within 30 cycles", busy); end
    total++; if (wr_hi !== 0) begin bad++; $display("FAIL wblk_ready_busy got=%0d cycles want=0", wr_hi); end
    total++; if (rows !== N) begin bad++; $display("FAIL wblk_rows got=%0d want=%0d", rows, N); end
    total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL wblk_idle_ready got=%b want=1", w_ready); end
    step();
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wblk_accept busy=%b want=1", busy); end
    for (int i = 11; i < 14; i++) begin
      w_data = wbeat(i);
      step();
    end
    w_valid = 1'b0; w_data = '0;
    for (int k = 0; k < N; k++) begin
      #1;
      total++; if (b_out !== wbeat(10 + k)) begin bad++; $display("FAIL wblk_emit k=%0d got=%h want=%h", k, b_out, wbeat(10 + k)); end
      step();
    end
  endtask

  initial begin
    w_valid = 1'b0; w_data = '0;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    r_ready = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        results_in[(r*N + c)*DB +: DB] = 16'hA000 + 16'(r * 16 + c);
    test_reset();
    test_weight_load();
    test_single_activation();
    test_bubbles();
    test_result_backpressure();
    test_reset_mid_flush();
    test_w_blocked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
